acc_serial_ctrl: RTL

Bit-serial adder controller that sequences the `acc` carry cell. The cell is a 3-input combinational carry function: a, b, c -> saida = majority(a, b, c).
- The controller holds two WIDTH-bit operands and presents one bit pair plus the running carry per clock, LSB first.
- It registers the carry returned by the cell and builds the sum word internally.
- A start/busy/done handshake lets upper-level ADDAC logic request one addition at a time.

---
 rtl/acc_serial_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/acc_serial_ctrl.sv
// Bit-serial adder controller that sequences the acc majority carry cell, LSB first.
// Define ACC_SUB_EN to turn on subtraction (sub=1 -> op_a - op_b).
module acc (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic saida
);
  assign saida = (a & b) | (a & c) | (b & c);
endmodule

module acc_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_c,
  input  logic             cell_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] soma,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sha_reg, shb_reg, soma_reg;
  logic [WIDTH-1:0] sha_shift, shb_shift;
  logic [CW-1:0]    count_reg;
  logic             carry_reg, cout_reg, busy_reg, done_reg;
  logic             in_run, sum_bit, last_bit;
  logic [WIDTH-1:0] load_b;
  logic             load_c;

`ifdef ACC_SUB_EN
  // Two's-complement subtract: invert B and force the carry-in.
  assign load_b = sub ? ~op_b : op_b;
  assign load_c = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign load_b = op_b;
  assign load_c = cin;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_top
        assign sha_shift[gi] = 1'b0;
        assign shb_shift[gi] = 1'b0;
      end else begin : g_mid
        assign sha_shift[gi] = sha_reg[gi+1];
        assign shb_shift[gi] = shb_reg[gi+1];
      end
    end
  endgenerate

  assign in_run   = (state_reg == RUN);
  assign cell_a   = in_run & sha_reg[0];
  assign cell_b   = in_run & shb_reg[0];
  assign cell_c   = in_run & carry_reg;
  assign sum_bit  = sha_reg[0] ^ shb_reg[0] ^ carry_reg;
  assign last_bit = (count_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      sha_reg   <= '0;
      shb_reg   <= '0;
      soma_reg  <= '0;
      count_reg <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            sha_reg   <= op_a;
            shb_reg   <= load_b;
            carry_reg <= load_c;
            count_reg <= '0;
            soma_reg  <= '0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          sha_reg   <= sha_shift;
          shb_reg   <= shb_shift;
          soma_reg  <= {sum_bit, soma_reg[WIDTH-1:1]};
          carry_reg <= cell_carry;
          count_reg <= count_reg + 1'b1;
          if (last_bit) begin
            cout_reg  <= cell_carry;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign soma = soma_reg;
  assign cout = cout_reg;
endmodule
